tiny_cpu_top: RTL and testbench

- Top level of a single-cycle 8-bit accumulator CPU for an FPGA board.
- Contains a 16x8 instruction ROM, a 16x8 data RAM, an accumulator, a 4-bit PC and Z/C flags.
- Button-driven run/step control; 8-bit switch input port.
- Eight-digit multiplexed 7-segment display shows CPU state as two 4-digit groups.

---
 rtl/tiny_cpu_top.sv | 156 +++++++++++++++
 tb/tb_tiny_cpu_top.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_cpu_top.sv
// Single-cycle 8-bit accumulator CPU with button run/step control and an
// eight-digit multiplexed 7-segment view of ACC, PC, flags, IR and switches.
module tiny_cpu_top #(
    parameter int SCAN_BITS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn,
    input  logic [7:0] switch,
    output logic [7:0] seg_code_0,
    output logic [7:0] seg_code_1,
    output logic [7:0] pos
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0, OP_LDI  = 4'h1, OP_ADDI = 4'h2, OP_SUBI = 4'h3,
        OP_IN   = 4'h4, OP_ANDI = 4'h5, OP_ORI  = 4'h6, OP_XORI = 4'h7,
        OP_LD   = 4'h8, OP_ST   = 4'h9, OP_JMP  = 4'hA, OP_JZ   = 4'hB,
        OP_JNZ  = 4'hC, OP_SHL  = 4'hD, OP_SHR  = 4'hE, OP_HALT = 4'hF
    } op_e;

    logic [7:0]           acc;
    logic [3:0]           pc;
    logic                 z, c, run, halt;
    logic [7:0]           ram [16];
    logic [1:0]           sync1, sync2, prev;
    logic [SCAN_BITS-1:0] scan_cnt;

    logic [7:0] ir;
    op_e        op;
    logic [3:0] k;
    logic       run_pulse, step_pulse, commit;
    logic [7:0] acc_nxt;
    logic [3:0] pc_nxt;
    logic       c_nxt, acc_we, ram_we, halt_nxt;
    logic [8:0] sum9, diff9;

    logic unused_btn;
    assign unused_btn = ^btn[4:2];

    always_comb begin
        unique case (pc)
            4'h0:    ir = 8'h40;
            4'h1:    ir = 8'h21;
            4'h2:    ir = 8'h90;
            4'h3:    ir = 8'hB5;
            4'h4:    ir = 8'hA1;
            4'h5:    ir = 8'hF0;
            default: ir = 8'h00;
        endcase
    end

    assign op = op_e'(ir[7:4]);
    assign k  = ir[3:0];

    // A button sampled high at edge N pulses during the cycle after edge N+1.
    assign run_pulse  = sync2[0] & ~prev[0];
    assign step_pulse = sync2[1] & ~prev[1];
    assign commit     = ~halt & (run | (step_pulse & ~run_pulse));

    assign sum9  = {1'b0, acc} + {5'b0, k};
    assign diff9 = {1'b0, acc} - {5'b0, k};

    // NOTE: every output gets a default first so no path leaves a latch.
    always_comb begin
        acc_nxt  = acc;
        c_nxt    = c;
        pc_nxt   = pc + 4'd1;
        acc_we   = 1'b0;
        ram_we   = 1'b0;
        halt_nxt = halt;
        case (op)
            OP_LDI:  begin acc_nxt = {4'h0, k};             acc_we = 1'b1; end
            OP_ADDI: begin {c_nxt, acc_nxt} = sum9;         acc_we = 1'b1; end
            OP_SUBI: begin {c_nxt, acc_nxt} = diff9;        acc_we = 1'b1; end
            OP_IN:   begin acc_nxt = switch;                acc_we = 1'b1; end
            OP_ANDI: begin acc_nxt = acc & {4'h0, k};       acc_we = 1'b1; end
            OP_ORI:  begin acc_nxt = acc | {4'h0, k};       acc_we = 1'b1; end
            OP_XORI: begin acc_nxt = acc ^ {4'h0, k};       acc_we = 1'b1; end
            OP_LD:   begin acc_nxt = ram[k];                acc_we = 1'b1; end
            OP_ST:   ram_we = 1'b1;
            OP_JMP:  pc_nxt = k;
            OP_JZ:   if (z)  pc_nxt = k;
            OP_JNZ:  if (!z) pc_nxt = k;
            OP_SHL:  begin c_nxt = acc[7]; acc_nxt = {acc[6:0], 1'b0}; acc_we = 1'b1; end
            OP_SHR:  begin c_nxt = acc[0]; acc_nxt = {1'b0, acc[7:1]}; acc_we = 1'b1; end
            OP_HALT: begin halt_nxt = 1'b1; pc_nxt = pc; end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            pc       <= '0;
            z        <= 1'b0;
            c        <= 1'b0;
            run      <= 1'b0;
            halt     <= 1'b0;
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            scan_cnt <= '0;
            // NOTE: the data RAM must read as zero after reset, so it is built
            // from flops rather than a block RAM that cannot be reset.
            for (int i = 0; i < 16; i++) ram[i] <= '0;
        end else begin
            sync1    <= btn[1:0];
            sync2    <= sync1;
            prev     <= sync2;
            scan_cnt <= scan_cnt + SCAN_BITS'(1);
            if (run_pulse && !halt) run <= ~run;
            if (commit) begin
                pc   <= pc_nxt;
                c    <= c_nxt;
                halt <= halt_nxt;
                if (acc_we) begin
                    acc <= acc_nxt;
                    z   <= (acc_nxt == 8'h00);
                end
                if (ram_we) ram[k] <= acc;
            end
        end
    end

    function automatic logic [7:0] font(input logic [3:0] d);
        case (d)
            4'h0: font = 8'h3F;  4'h1: font = 8'h06;  4'h2: font = 8'h5B;  4'h3: font = 8'h4F;
            4'h4: font = 8'h66;  4'h5: font = 8'h6D;  4'h6: font = 8'h7D;  4'h7: font = 8'h07;
            4'h8: font = 8'h7F;  4'h9: font = 8'h6F;  4'hA: font = 8'h77;  4'hB: font = 8'h7C;
            4'hC: font = 8'h39;  4'hD: font = 8'h5E;  4'hE: font = 8'h79;  default: font = 8'h71;
        endcase
    endfunction

    logic [1:0] scan_k;
    logic [3:0] digit_lo, digit_hi, onehot;

    assign scan_k = scan_cnt[SCAN_BITS-1 -: 2];
    assign onehot = 4'b0001 << scan_k;

    always_comb begin
        case (scan_k)
            2'd0:    begin digit_lo = acc[3:0];             digit_hi = ir[3:0];     end
            2'd1:    begin digit_lo = acc[7:4];             digit_hi = ir[7:4];     end
            2'd2:    begin digit_lo = pc;                   digit_hi = switch[3:0]; end
            default: begin digit_lo = {halt, run, c, z};    digit_hi = switch[7:4]; end
        endcase
    end

    assign pos        = {onehot, onehot};
    assign seg_code_0 = font(digit_lo);
    assign seg_code_1 = font(digit_hi);

endmodule

// File: tb/tb_tiny_cpu_top.sv
// Directed bench for tiny_cpu_top: reads CPU state back through the scanned
// display (SCAN_BITS=2) and compares against hand-computed values.
module tb_tiny_cpu_top;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn;
    logic [7:0] switch;
    logic [7:0] seg_code_0, seg_code_1, pos;

    int tests = 0;
    int fails = 0;

    logic [7:0] got_lo [4];
    logic [7:0] got_hi [4];

    tiny_cpu_top #(.SCAN_BITS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .switch     (switch),
        .seg_code_0 (seg_code_0),
        .seg_code_1 (seg_code_1),
        .pos        (pos)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] font(input logic [3:0] d);
        case (d)
            4'h0: font = 8'h3F;  4'h1: font = 8'h06;  4'h2: font = 8'h5B;  4'h3: font = 8'h4F;
            4'h4: font = 8'h66;  4'h5: font = 8'h6D;  4'h6: font = 8'h7D;  4'h7: font = 8'h07;
            4'h8: font = 8'h7F;  4'h9: font = 8'h6F;  4'hA: font = 8'h77;  4'hB: font = 8'h7C;
            4'hC: font = 8'h39;  4'hD: font = 8'h5E;  4'hE: font = 8'h79;  default: font = 8'h71;
        endcase
    endfunction

    // Expected digit i is nibble i of {switch, ir, flags, pc, acc}.
    function automatic logic [31:0] pack_digits(input logic [7:0] acc, input logic [3:0] pc,
                                                 input logic [3:0] flags, input logic [7:0] ir,
                                                 input logic [7:0] sw);
        pack_digits = {sw, ir, flags, pc, acc};
    endfunction

    function automatic logic [7:0] got_digit(input int i);
        got_digit = (i < 4) ? got_lo[i] : got_hi[i-4];
    endfunction

    task automatic read_digits();
        for (int i = 0; i < 4; i++) begin
            got_lo[i] = 8'hxx;
            got_hi[i] = 8'hxx;
        end
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            case (pos)
                8'h11: begin got_lo[0] = seg_code_0; got_hi[0] = seg_code_1; end
                8'h22: begin got_lo[1] = seg_code_0; got_hi[1] = seg_code_1; end
                8'h44: begin got_lo[2] = seg_code_0; got_hi[2] = seg_code_1; end
                8'h88: begin got_lo[3] = seg_code_0; got_hi[3] = seg_code_1; end
                default: ;
            endcase
        end
    endtask

    task automatic press(input logic [4:0] mask);
        @(negedge clk) btn = mask;
        @(negedge clk) btn = 5'b0;
    endtask

    task automatic step_once();
        press(5'b00010);
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] exp_pos [4];
        logic [7:0] exp_s0  [4];
        logic [7:0] exp_s1  [4];
        exp_pos = '{8'h11, 8'h22, 8'h44, 8'h88};
        exp_s0  = '{8'h3F, 8'h3F, 8'h3F, 8'h3F};
        exp_s1  = '{8'h3F, 8'h66, 8'h6D, 8'h77};
        #12;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1) rst = 1'b1;
            if (i == 1) @(negedge clk);
            tests++;
            if (pos !== exp_pos[i]) begin
                fails++;
                $display("FAIL reset_scan pos[%0d]: got %h expected %h", i, pos, exp_pos[i]);
            end
            tests++;
            if (seg_code_0 !== exp_s0[i]) begin
                fails++;
                $display("FAIL reset_scan seg0[%0d]: got %h expected %h", i, seg_code_0, exp_s0[i]);
            end
            tests++;
            if (seg_code_1 !== exp_s1[i]) begin
                fails++;
                $display("FAIL reset_scan seg1[%0d]: got %h expected %h", i, seg_code_1, exp_s1[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        @(negedge clk) switch = 8'hFE;
        @(negedge clk) btn = 5'b00010;
        @(negedge clk) btn = 5'b00000;
        @(negedge clk) btn = 5'b00010;
        @(negedge clk) btn = 5'b00000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        read_digits();
        exp = pack_digits(8'hFF, 4'h2, 4'h0, 8'h90, 8'hFE);
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (got_digit(i) !== font(exp[4*i +: 4])) begin
                fails++;
                $display("FAIL back_to_back digit %0d: got %h expected %h", i, got_digit(i), font(exp[4*i +: 4]));
            end
        end
    endtask

    task automatic test_step_program();
        logic [7:0] e_acc [7];
        logic [3:0] e_pc  [7];
        logic [3:0] e_fl  [7];
        logic [7:0] e_ir  [7];
        logic [7:0] e_ram [7];
        logic [31:0] exp;
        e_acc = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        e_pc  = '{4'h3,  4'h4,  4'h1,  4'h2,  4'h3,  4'h5,  4'h5};
        e_fl  = '{4'h0,  4'h0,  4'h0,  4'h3,  4'h3,  4'h3,  4'hB};
        e_ir  = '{8'hB5, 8'hA1, 8'h21, 8'h90, 8'hB5, 8'hF0, 8'hF0};
        e_ram = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
        for (int s = 0; s < 7; s++) begin
            step_once();
            read_digits();
            exp = pack_digits(e_acc[s], e_pc[s], e_fl[s], e_ir[s], 8'hFE);
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (got_digit(i) !== font(exp[4*i +: 4])) begin
                    fails++;
                    $display("FAIL step%0d digit %0d: got %h expected %h", s + 3, i, got_digit(i), font(exp[4*i +: 4]));
                end
            end
            tests++;
            if (dut.ram[0] !== e_ram[s]) begin
                fails++;
                $display("FAIL step%0d ram0: got %h expected %h", s + 3, dut.ram[0], e_ram[s]);
            end
        end
    endtask

    task automatic test_halt_lock();
        logic [31:0] exp;
        step_once();
        press(5'b00001);
        repeat (3) @(posedge clk);
        step_once();
        read_digits();
        exp = pack_digits(8'h00, 4'h5, 4'h0, 8'hF0, 8'hFE);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) continue;
            tests++;
            if (got_digit(i) !== font(exp[4*i +: 4])) begin
                fails++;
                $display("FAIL halt_lock digit %0d: got %h expected %h", i, got_digit(i), font(exp[4*i +: 4]));
            end
        end
    endtask

    task automatic test_run_loop();
        logic [31:0] exp;
        int halt_cycle = -1;
        do_reset();
        switch = 8'h00;
        press(5'b00011);
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) begin
                tests++;
                if (dut.run !== 1'b1 || dut.pc !== 4'h0) begin
                    fails++;
                    $display("FAIL run_and_step run/pc: got %b/%h expected 1/0", dut.run, dut.pc);
                end
            end
            if (c == 3) begin
                tests++;
                if (dut.pc !== 4'h1) begin
                    fails++;
                    $display("FAIL run_first_commit pc: got %h expected 1", dut.pc);
                end
            end
            if (dut.halt === 1'b1) begin
                halt_cycle = c;
                break;
            end
        end
        tests++;
        if (halt_cycle != 1027) begin
            fails++;
            $display("FAIL run_halt_cycle: got %0d expected 1027", halt_cycle);
        end
        @(negedge clk);
        read_digits();
        exp = pack_digits(8'h00, 4'h5, 4'hF, 8'hF0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (got_digit(i) !== font(exp[4*i +: 4])) begin
                fails++;
                $display("FAIL run_loop digit %0d: got %h expected %h", i, got_digit(i), font(exp[4*i +: 4]));
            end
        end
        tests++;
        if (dut.ram[0] !== 8'h00) begin
            fails++;
            $display("FAIL run_loop ram0: got %h expected 00", dut.ram[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] exp;
        do_reset();
        switch = 8'h5A;
        press(5'b00001);
        repeat (20) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        tests++;
        if (pos !== 8'h11 || seg_code_0 !== 8'h3F || seg_code_1 !== 8'h3F) begin
            fails++;
            $display("FAIL async_reset display: got %h/%h/%h expected 11/3F/3F", pos, seg_code_0, seg_code_1);
        end
        tests++;
        if (dut.pc !== 4'h0 || dut.run !== 1'b0 || dut.acc !== 8'h00) begin
            fails++;
            $display("FAIL async_reset pc/run/acc: got %h/%b/%h expected 0/0/00", dut.pc, dut.run, dut.acc);
        end
        tests++;
        if (dut.ram[0] !== 8'h00) begin
            fails++;
            $display("FAIL async_reset ram0: got %h expected 00", dut.ram[0]);
        end
        @(negedge clk) rst = 1'b1;
        repeat (10) @(posedge clk);
        read_digits();
        exp = pack_digits(8'h00, 4'h0, 4'h0, 8'h40, 8'h5A);
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (got_digit(i) !== font(exp[4*i +: 4])) begin
                fails++;
                $display("FAIL idle_after_reset digit %0d: got %h expected %h", i, got_digit(i), font(exp[4*i +: 4]));
            end
        end
        step_once();
        read_digits();
        exp = pack_digits(8'h5A, 4'h1, 4'h0, 8'h21, 8'h5A);
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (got_digit(i) !== font(exp[4*i +: 4])) begin
                fails++;
                $display("FAIL step_after_reset digit %0d: got %h expected %h", i, got_digit(i), font(exp[4*i +: 4]));
            end
        end
    endtask

    initial begin
        rst    = 1'b0;
        btn    = 5'b0;
        switch = 8'hA5;
        test_reset();
        test_back_to_back();
        test_step_program();
        test_halt_lock();
        test_run_loop();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
